axil_timer: RTL

- AXI4-Lite slave timer peripheral. It sits directly downstream of the LSU interconnect's AXI4-Lite master port, in the MMIO region.
- Provides a 32-bit prescaled up-counter, a compare register, a sticky match flag and a level interrupt to the core.
- Upper address bits are decoded by the interconnect. This block decodes only the low byte offset.

---
 rtl/axil_timer.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/axil_timer.sv
// rtl/axil_timer.sv - AXI4-Lite slave timer: prescaled 32-bit counter, compare, sticky match, irq
//
// Purpose: memory-mapped timer peripheral. Only the low address byte is decoded;
// word offsets 0x00 CTRL, 0x04 PRESCALE, 0x08 COUNT, 0x0C COMPARE, 0x10 STATUS.
// Any other offset reads 0, ignores writes and answers SLVERR.
//
// Ports:
//   clk, nrst                      clock, asynchronous active-low reset
//   awaddr/awprot/awvalid/awready  write address channel
//   wdata/wstrb/wvalid/wready      write data channel
//   bresp/bvalid/bready            write response channel
//   araddr/arprot/arvalid/arready  read address channel
//   rdata/rresp/rvalid/rready      read data channel
//   irq                            level interrupt, registered
module axil_timer #(
  parameter int unsigned PRESCALE_WIDTH = 16,
  parameter logic [31:0] COMPARE_RESET  = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [31:0] awaddr,
  input  logic [2:0]  awprot,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready,
  input  logic [31:0] araddr,
  input  logic [2:0]  arprot,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  output logic        irq
);

  localparam int unsigned PW = PRESCALE_WIDTH;

  // Architectural registers
  logic [2:0]    ctrl;       // {IRQ_EN, AUTO_CLR, EN}
  logic [PW-1:0] prescale;
  logic [PW-1:0] pre_cnt;
  logic [31:0]   count;
  logic [31:0]   compare;
  logic          match;

  // Write-channel holding registers; AW and W are captured independently
  logic          aw_held;
  logic [5:0]    aw_word;
  logic          w_held;
  logic [31:0]   w_data;
  logic [3:0]    w_strb;

  assign awready = !aw_held && !bvalid;
  assign wready  = !w_held && !bvalid;
  assign arready = !rvalid;

  function automatic logic [31:0] lane_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    for (int i = 0; i < 4; i++)
      res[i*8 +: 8] = strb[i] ? new_val[i*8 +: 8] : old_val[i*8 +: 8];
    return res;
  endfunction

  // Write decode: the commit happens in the cycle where both halves are held
  logic        wr_commit, wr_err;
  logic        wr_ctrl, wr_prescale, wr_count, wr_compare, wr_status;
  logic [31:0] wr_old, wr_merged;

  assign wr_commit   = aw_held && w_held;
  assign wr_err      = aw_word > 6'd4;
  assign wr_ctrl     = wr_commit && (aw_word == 6'd0);
  assign wr_prescale = wr_commit && (aw_word == 6'd1);
  assign wr_count    = wr_commit && (aw_word == 6'd2);
  assign wr_compare  = wr_commit && (aw_word == 6'd3);
  assign wr_status   = wr_commit && (aw_word == 6'd4);

  always_comb begin
    wr_old = 32'd0;
    case (aw_word)
      6'd0:    wr_old = {29'd0, ctrl};
      6'd1:    wr_old = 32'(prescale);
      6'd2:    wr_old = count;
      6'd3:    wr_old = compare;
      default: wr_old = 32'd0;
    endcase
  end

  assign wr_merged = lane_merge(wr_old, w_data, w_strb);

  // Read mux, sampled at the AR handshake edge
  logic [31:0] rd_val;
  logic        rd_err;

  assign rd_err = araddr[7:2] > 6'd4;

  always_comb begin
    rd_val = 32'd0;
    case (araddr[7:2])
      6'd0:    rd_val = {29'd0, ctrl};
      6'd1:    rd_val = 32'(prescale);
      6'd2:    rd_val = count;
      6'd3:    rd_val = compare;
      6'd4:    rd_val = {31'd0, match};
      default: rd_val = 32'd0;
    endcase
  end

  // Timer datapath. A PRESCALE write restarts the prescaler and swallows that tick.
  logic tick, hit, w1c, match_next;

  assign tick       = ctrl[0] && (pre_cnt == prescale) && !wr_prescale;
  assign hit        = tick && (count == compare);
  assign w1c        = wr_status && w_strb[0] && w_data[0];
  assign match_next = hit || (match && !w1c);   // set beats clear

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      aw_held  <= 1'b0;
      aw_word  <= 6'd0;
      w_held   <= 1'b0;
      w_data   <= 32'd0;
      w_strb   <= 4'd0;
      bvalid   <= 1'b0;
      bresp    <= 2'b00;
      rvalid   <= 1'b0;
      rdata    <= 32'd0;
      rresp    <= 2'b00;
      ctrl     <= 3'd0;
      prescale <= '0;
      pre_cnt  <= '0;
      count    <= 32'd0;
      compare  <= COMPARE_RESET;
      match    <= 1'b0;
      irq      <= 1'b0;
    end else begin
      if (awvalid && awready) begin
        aw_held <= 1'b1;
        aw_word <= awaddr[7:2];
      end
      if (wvalid && wready) begin
        w_held <= 1'b1;
        w_data <= wdata;
        w_strb <= wstrb;
      end
      if (wr_commit) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
        bvalid  <= 1'b1;
        bresp   <= wr_err ? 2'b10 : 2'b00;
      end else if (bvalid && bready) begin
        bvalid <= 1'b0;
      end

      if (rvalid) begin
        if (rready) rvalid <= 1'b0;
      end else if (arvalid) begin
        rvalid <= 1'b1;
        rdata  <= rd_val;
        rresp  <= rd_err ? 2'b10 : 2'b00;
      end

      if (wr_ctrl)     ctrl     <= wr_merged[2:0];
      if (wr_prescale) prescale <= wr_merged[PW-1:0];
      if (wr_compare)  compare  <= wr_merged;

      if (!ctrl[0] || wr_prescale || tick) pre_cnt <= '0;
      else                                 pre_cnt <= pre_cnt + PW'(1);

      // A software COUNT write overrides a coincident tick
      if (wr_count)  count <= wr_merged;
      else if (tick) count <= (hit && ctrl[1]) ? 32'd0 : count + 32'd1;

      match <= match_next;
      irq   <= match_next && ctrl[2];
    end
  end

  logic unused_bits;
  assign unused_bits = ^{awaddr[31:8], awaddr[1:0], awprot,
                         araddr[31:8], araddr[1:0], arprot, wr_merged};

endmodule
